// File: rtl/tdc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdc_pkg
// Description : Shared types and constants for the TDC event assembler:
//               fine-code width, record flag bit positions, FSM state
//               encoding and the packed record flag struct.
// Revision    : 1.0 - initial release
// ============================================================================
package tdc_pkg;

  // Width of the head/tail fine codes
  localparam int FINE_W = 6;

  // Bit positions of the status flags inside a record
  localparam int FLG_COINC = 0;
  localparam int FLG_SAT   = 1;
  localparam int FLG_NEG   = 2;
  localparam int FLAG_W    = 3;

  // Measurement FSM states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Record flag field; member order matches FLG_NEG/FLG_SAT/FLG_COINC
  typedef struct packed {
    logic neg;
    logic sat;
    logic coinc;
  } rec_flags_t;

endpackage : tdc_pkg
`default_nettype wire

// File: rtl/tdc_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tdc_sync_fifo
// Description : Single-clock register FIFO with show-ahead read. The head
//               entry is presented combinationally on rd_data. A write while
//               full is accepted when a read happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Pointers carry one wrap bit so full and empty are distinguishable
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage write; cleared on reset so the idle head entry reads as zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Read and write pointer advance
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule : tdc_sync_fifo
`default_nettype wire

// File: rtl/tdc_event_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tdc_event_assembler
// Description : Pairs TDC head (start) fine codes with the following tail
//               (stop) fine codes, counts whole clock periods between them,
//               forms {flags, interval} records and buffers them in a FIFO
//               drained over valid/ready.
//               Optional feature macro: TDC_ASM_TIMEOUT_EN (closes an open
//               measurement with a saturated record after TIMEOUT periods).
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_event_assembler
  import tdc_pkg::*;
#(
  parameter int COARSE_W = 10,
  parameter int DEPTH    = 8,
  parameter int TIMEOUT  = 1000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [FINE_W-1:0]            head_code,
  input  logic                         head_wr,
  input  logic [FINE_W-1:0]            tail_code,
  input  logic                         tail_wr,
  output logic [FLAG_W+COARSE_W+5:0]   out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   drop_cnt,
  output logic                         busy
);

  localparam int MEAS_W = COARSE_W + FINE_W;
  localparam int REC_W  = FLAG_W + MEAS_W;
  localparam int RAW_W  = COARSE_W + FINE_W + 1;
  localparam logic [COARSE_W-1:0] COARSE_MAX = '1;

  // Elaboration-time parameter sanity checks
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  // FSM and open-measurement state
  state_t              state;
  state_t              state_nx;
  logic [COARSE_W-1:0] coarse;
  logic [COARSE_W-1:0] coarse_nx;
  logic [COARSE_W-1:0] coarse_inc;
  logic [FINE_W-1:0]   head_q;
  logic [FINE_W-1:0]   head_nx;

  // Close request towards the capture stage
  logic                close_now;
  logic                timeout_now;
  logic [COARSE_W-1:0] close_coarse;
  logic [FINE_W-1:0]   close_head;
  logic                drop_evt;

  // Capture stage (loaded on the edge that samples the tail)
  logic                cap_valid;
  logic                cap_timeout;
  logic [COARSE_W-1:0] cap_coarse;
  logic [FINE_W-1:0]   cap_head;
  logic [FINE_W-1:0]   cap_tail;

  // Result stage
  logic [RAW_W-1:0]    raw;
  rec_flags_t          flags_c;
  logic [MEAS_W-1:0]   meas_c;
  logic                res_valid;
  logic [REC_W-1:0]    res_rec;

  // FIFO side
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                fifo_drop;
  logic [1:0]          drop_inc;
  logic [8:0]          drop_sum;

  // FSM state, coarse counter and latched head code
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      coarse <= '0;
      head_q <= '0;
    end else begin
      state  <= state_nx;
      coarse <= coarse_nx;
      head_q <= head_nx;
    end
  end

  // Next-state logic: pairing of head/tail strobes, drops and timeout
  always_comb begin
    state_nx     = state;
    coarse_nx    = coarse;
    head_nx      = head_q;
    close_now    = 1'b0;
    timeout_now  = 1'b0;
    close_coarse = '0;
    close_head   = head_q;
    drop_evt     = 1'b0;
    coarse_inc   = (coarse == COARSE_MAX) ? COARSE_MAX : coarse + 1'b1;
    case (state)
      IDLE: begin
        if (head_wr && tail_wr) begin
          // Start and stop in the same cycle: zero whole periods
          close_now    = 1'b1;
          close_coarse = '0;
          close_head   = head_code;
        end else if (head_wr) begin
          head_nx   = head_code;
          coarse_nx = '0;
          state_nx  = RUN;
        end else if (tail_wr) begin
          drop_evt = 1'b1;
        end
      end
      RUN: begin
        coarse_nx = coarse_inc;
        if (tail_wr) begin
          // Tail sampled one period after the counter value seen here
          close_now    = 1'b1;
          close_coarse = coarse_inc;
          close_head   = head_q;
          if (head_wr) begin
            head_nx   = head_code;
            coarse_nx = '0;
          end else begin
            coarse_nx = '0;
            state_nx  = IDLE;
          end
        end else if (head_wr) begin
          head_nx   = head_code;
          coarse_nx = '0;
          drop_evt  = 1'b1;
        end
`ifdef TDC_ASM_TIMEOUT_EN
        else if (32'(coarse) == TIMEOUT) begin
          timeout_now = 1'b1;
          coarse_nx   = '0;
          state_nx    = IDLE;
        end
`endif
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign busy = (state == RUN);

  // Capture stage: freeze the operands of a closed measurement
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_valid   <= 1'b0;
      cap_timeout <= 1'b0;
      cap_coarse  <= '0;
      cap_head    <= '0;
      cap_tail    <= '0;
    end else begin
      cap_valid   <= close_now || timeout_now;
      cap_timeout <= timeout_now;
      cap_coarse  <= close_coarse;
      cap_head    <= close_head;
      cap_tail    <= tail_code;
    end
  end

  // Interval arithmetic: coarse*64 + head - tail, sign in the top bit
  always_comb begin
    raw           = RAW_W'({cap_coarse, {FINE_W{1'b0}}}) + RAW_W'(cap_head) - RAW_W'(cap_tail);
    flags_c.coinc = !cap_timeout && (cap_tail == '0);
    flags_c.sat   = cap_timeout || (cap_coarse == COARSE_MAX);
    flags_c.neg   = !cap_timeout && raw[RAW_W-1];
    if (cap_timeout) begin
      meas_c = '1;
    end else if (raw[RAW_W-1]) begin
      meas_c = '0;
    end else begin
      meas_c = raw[MEAS_W-1:0];
    end
  end

  // Result register feeding the FIFO write port
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_rec   <= '0;
    end else begin
      res_valid <= cap_valid;
      res_rec   <= {flags_c, meas_c};
    end
  end

  tdc_sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_data (res_rec),
    .wr_en   (res_valid),
    .rd_en   (pop),
    .rd_data (out_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign fifo_drop = res_valid && fifo_full && !pop;
  assign drop_inc  = {1'b0, drop_evt} + {1'b0, fifo_drop};
  assign drop_sum  = {1'b0, drop_cnt} + {7'b0, drop_inc};

  // Saturating lost-event counter
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else begin
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

endmodule : tdc_event_assembler
`default_nettype wire

// File: tb/tb_tdc_event_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdc_event_assembler
// Description : Directed self-checking bench for tdc_event_assembler. A main
//               instance (COARSE_W=10, DEPTH=8, TIMEOUT=16) covers pairing,
//               flags, drops and FIFO behaviour; a small instance
//               (COARSE_W=4, DEPTH=2) covers coarse saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdc_event_assembler;

  logic        clk;
  logic        rst;
  logic [5:0]  head_code;
  logic        head_wr;
  logic [5:0]  tail_code;
  logic        tail_wr;
  logic [18:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  drop_cnt;
  logic        busy;

  logic [5:0]  s_head_code;
  logic        s_head_wr;
  logic [5:0]  s_tail_code;
  logic        s_tail_wr;
  logic [12:0] s_out_data;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [7:0]  s_drop_cnt;
  logic        s_busy;

  int vectors;
  int miscompares;

  tdc_event_assembler #(.COARSE_W(10), .DEPTH(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .head_code(head_code), .head_wr(head_wr),
    .tail_code(tail_code), .tail_wr(tail_wr),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  tdc_event_assembler #(.COARSE_W(4), .DEPTH(2), .TIMEOUT(1000)) dut_small (
    .clk(clk), .rst(rst),
    .head_code(s_head_code), .head_wr(s_head_wr),
    .tail_code(s_tail_code), .tail_wr(s_tail_wr),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .drop_cnt(s_drop_cnt), .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] rec(input logic [2:0] fl, input logic [15:0] m);
    return {fl, m};
  endfunction

  // One clock edge; strobes are single-cycle so they are cleared afterwards
  task automatic tick();
    @(posedge clk);
    #1;
    head_wr   = 1'b0;
    tail_wr   = 1'b0;
    s_head_wr = 1'b0;
    s_tail_wr = 1'b0;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    out_ready   = 1'b0;
    s_out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 19'd0 || drop_cnt !== 8'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: valid=%b data=%h drop=%0d busy=%b, want 0/0/0/0",
               out_valid, out_data, drop_cnt, busy);
    end
    // Reset with a closed measurement in the pipeline: no record
    head_code = 6'd5; head_wr = 1'b1; tick();
    tail_code = 6'd1; tail_wr = 1'b1; tick();
    rst = 1'b1; tick(); rst = 1'b0;
    tick(); tick(); tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pipeline: out_valid=%b, want 0", out_valid);
    end
    // Reset mid-RUN: open measurement discarded, later tail is an orphan
    head_code = 6'd7; head_wr = 1'b1; tick();
    rst = 1'b1; tick(); rst = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midrun_busy: busy=%b, want 0", busy);
    end
    tail_code = 6'd2; tail_wr = 1'b1; tick();
    tick(); tick(); tick();
    vectors++;
    if (drop_cnt !== 8'd1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midrun_orphan: drop=%0d valid=%b, want 1/0", drop_cnt, out_valid);
    end
  endtask

  task automatic test_basic();
    do_reset();
    head_code = 6'd10; head_wr = 1'b1; tick();           // edge 0
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_busy: busy=%b, want 1", busy);
    end
    tick(); tick(); tick(); tick();                       // edges 1..4
    tail_code = 6'd4; tail_wr = 1'b1; tick();             // edge 5
    tick();                                               // edge 6
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_latency: valid=%b busy=%b after edge 6, want 0/0", out_valid, busy);
    end
    tick();                                               // edge 7
    vectors++;
    if (out_valid !== 1'b1 || out_data !== rec(3'b000, 16'd326)) begin
      miscompares++;
      $display("FAIL basic_record: valid=%b data=%h, want 1/%h", out_valid, out_data, rec(3'b000, 16'd326));
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_pop: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_coinc_neg();
    do_reset();
    head_code = 6'd3; tail_code = 6'd0; head_wr = 1'b1; tail_wr = 1'b1; tick();
    head_code = 6'd0; tail_code = 6'd20; head_wr = 1'b1; tail_wr = 1'b1; tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL coinc_busy: busy=%b, want 0", busy);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== rec(3'b001, 16'd3)) begin
      miscompares++;
      $display("FAIL coinc_record: valid=%b data=%h, want 1/%h", out_valid, out_data, rec(3'b001, 16'd3));
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== rec(3'b100, 16'd0)) begin
      miscompares++;
      $display("FAIL neg_record: valid=%b data=%h, want 1/%h", out_valid, out_data, rec(3'b100, 16'd0));
    end
  endtask

  task automatic test_orphan_restart();
    do_reset();
    tail_code = 6'd3; tail_wr = 1'b1; tick();
    vectors++;
    if (drop_cnt !== 8'd1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL orphan_drop: drop=%0d busy=%b, want 1/0", drop_cnt, busy);
    end
    head_code = 6'd7; head_wr = 1'b1; tick();             // edge a
    tick();
    head_code = 6'd9; head_wr = 1'b1; tick();             // edge a+2
    vectors++;
    if (drop_cnt !== 8'd2 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_drop: drop=%0d busy=%b, want 2/1", drop_cnt, busy);
    end
    tick(); tick();
    tail_code = 6'd5; tail_wr = 1'b1; tick();             // edge a+5, coarse 3
    tick(); tick();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== rec(3'b000, 16'd196)) begin
      miscompares++;
      $display("FAIL restart_record: valid=%b data=%h, want 1/%h", out_valid, out_data, rec(3'b000, 16'd196));
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || drop_cnt !== 8'd2) begin
      miscompares++;
      $display("FAIL restart_single: valid=%b drop=%0d, want 0/2", out_valid, drop_cnt);
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      head_code = 6'(i + 2); tail_code = 6'd1; head_wr = 1'b1; tail_wr = 1'b1; tick();
    end
    tick(); tick(); tick();
    vectors++;
    if (drop_cnt !== 8'd2 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL full_drop: drop=%0d valid=%b, want 2/1", drop_cnt, out_valid);
    end
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data !== rec(3'b000, 16'(j + 1))) begin
        miscompares++;
        $display("FAIL full_drain[%0d]: valid=%b data=%h, want 1/%h", j, out_valid, out_data, rec(3'b000, 16'(j + 1)));
      end
      tick();
    end
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL full_empty: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_m [8];
    do_reset();
    for (int i = 0; i < 8; i++) begin
      head_code = 6'(i + 2); tail_code = 6'd1; head_wr = 1'b1; tail_wr = 1'b1; tick();
    end
    head_code = 6'd20; tail_code = 6'd1; head_wr = 1'b1; tail_wr = 1'b1; tick();
    tick();                                               // FIFO now full
    out_ready = 1'b1; tick(); out_ready = 1'b0;           // pop and push together
    vectors++;
    if (drop_cnt !== 8'd0 || out_valid !== 1'b1 || out_data !== rec(3'b000, 16'd2)) begin
      miscompares++;
      $display("FAIL b2b_pushpop: drop=%0d valid=%b data=%h, want 0/1/%h", drop_cnt, out_valid, out_data, rec(3'b000, 16'd2));
    end
    for (int j = 0; j < 7; j++) exp_m[j] = 16'(j + 2);
    exp_m[7] = 16'd19;
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data !== rec(3'b000, exp_m[j])) begin
        miscompares++;
        $display("FAIL b2b_drain[%0d]: valid=%b data=%h, want 1/%h", j, out_valid, out_data, rec(3'b000, exp_m[j]));
      end
      tick();
    end
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_empty: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    s_head_code = 6'd2; s_head_wr = 1'b1; tick();         // edge 0
    for (int i = 0; i < 19; i++) tick();                  // edges 1..19
    s_tail_code = 6'd1; s_tail_wr = 1'b1; tick();         // edge 20
    tick(); tick();
    vectors++;
    if (s_out_valid !== 1'b1 || s_out_data !== {3'b010, 10'd961} || s_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_record: valid=%b data=%h busy=%b, want 1/%h/0", s_out_valid, s_out_data, s_busy, {3'b010, 10'd961});
    end
  endtask

`ifdef TDC_ASM_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    head_code = 6'd4; head_wr = 1'b1; tick();
    for (int n = 0; n < 40; n++) begin
      if (out_valid) break;
      tick();
    end
    vectors++;
    if (out_valid !== 1'b1 || out_data !== rec(3'b010, 16'hFFFF) || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_record: valid=%b data=%h busy=%b, want 1/%h/0", out_valid, out_data, busy, rec(3'b010, 16'hFFFF));
    end
    tail_code = 6'd3; tail_wr = 1'b1; tick();
    vectors++;
    if (drop_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL timeout_orphan: drop=%0d, want 1", drop_cnt);
    end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    head_code   = '0; head_wr = 1'b0;
    tail_code   = '0; tail_wr = 1'b0;
    out_ready   = 1'b0;
    s_head_code = '0; s_head_wr = 1'b0;
    s_tail_code = '0; s_tail_wr = 1'b0;
    s_out_ready = 1'b0;
    test_reset();
    test_basic();
    test_coinc_neg();
    test_orphan_restart();
    test_fifo_full();
    test_back_to_back();
    test_saturation();
`ifdef TDC_ASM_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_tdc_event_assembler
`default_nettype wire
